serial_subtractor: RTL

Bit-serial unsigned subtractor for the arithmetic lab datapath. It is the sequential, inverse-operation companion to the gate-level adder cells. It accepts two WIDTH-bit operands on a start strobe and computes a − b LSB-first, one bit per clock, using a full-subtractor cell and a borrow flip-flop. It then presents the difference and final borrow with a one-cycle done pulse.

---
 rtl/serial_subtractor_if.sv | 22 ++
 rtl/serial_subtractor.sv | 93 +++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  diff, bout, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, bout, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first unsigned a-b, one bit per clock with a borrow flop
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   sif
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             nb;
    logic             last;

    assign d    = ra[0] ^ rb[0] ^ br;
    assign nb   = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sif.start) state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sif.busy = 1'b0;
        sif.done = 1'b0;
        case (state_q)
            SHIFT:   sif.busy = 1'b1;
            DONE:    sif.done = 1'b1;
            default: ;
        endcase
    end

    // ra doubles as the result register: each difference bit enters at the MSB
    // as the consumed minuend bit leaves at the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra       <= '0;
            rb       <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            sif.diff <= '0;
            sif.bout <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sif.start) begin
                        ra  <= sif.a;
                        rb  <= sif.b;
                        br  <= 1'b0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    ra  <= {d, ra[WIDTH-1:1]};
                    rb  <= {1'b0, rb[WIDTH-1:1]};
                    br  <= nb;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        sif.diff <= {d, ra[WIDTH-1:1]};
                        sif.bout <= nb;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
